// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and connection controller for the serial
// bus interconnect. Each master sends a bit-serial frame (start bit, then the
// target slave ID MSB first) and holds its line high while it wants or owns
// the bus. One requester at a time is routed through the interconnect,
// granted once the slave reports ready, and torn down when its line drops.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_M[i]   serial request/hold line of master i
//   grant_M[i] bus granted to master i (registered)
//   ready      selected slave ready, returned from the interconnect
//   bus_state  {master_sel, slave_sel} to the interconnect (registered)
//   timeout    one-cycle pulse when a connection attempt is abandoned
module bus_arbiter #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS),
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_M [0:NO_MASTERS-1],
  output logic                           grant_M [0:NO_MASTERS-1],
  input  logic                           ready,
  output logic [M_ID_WIDTH+S_ID_WIDTH-1:0] bus_state,
  output logic                           timeout
);

  localparam int RX_CNT_W = $clog2(S_ID_WIDTH + 1);
  localparam int WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int BUS_W    = M_ID_WIDTH + S_ID_WIDTH;

  localparam logic [RX_CNT_W-1:0]   RX_CNT_ZERO = {RX_CNT_W{1'b0}};
  localparam logic [RX_CNT_W-1:0]   RX_CNT_ONE  = RX_CNT_W'(1);
  localparam logic [RX_CNT_W-1:0]   RX_LAST     = RX_CNT_W'(S_ID_WIDTH - 1);
  localparam logic [WAIT_W-1:0]     WAIT_ZERO   = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0]     WAIT_ONE    = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [S_ID_WIDTH-1:0] ID_ZERO     = {S_ID_WIDTH{1'b0}};
  localparam logic [M_ID_WIDTH-1:0] OWNER_RST   = M_ID_WIDTH'(NO_MASTERS - 1);
  localparam logic [BUS_W-1:0]      BUS_NONE    = {BUS_W{1'b0}};

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_HOLD  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONNECT = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // A frame names a real slave only for IDs 1..NO_SLAVES; 0 means "no slave".
  function automatic logic id_valid(input logic [S_ID_WIDTH-1:0] id);
    return (id != ID_ZERO) &&
           ({{(32-S_ID_WIDTH){1'b0}}, id} <= 32'(NO_SLAVES));
  endfunction

  logic [NO_MASTERS-1:0]                 pending_s;
  logic [NO_MASTERS-1:0][S_ID_WIDTH-1:0] id_s;
  logic [NO_MASTERS-1:0]                 drop_s;

  arb_state_e            state_r, state_nxt;
  logic [M_ID_WIDTH-1:0] owner_r, owner_nxt;
  logic [M_ID_WIDTH-1:0] last_owner_r, last_owner_nxt;
  logic [WAIT_W-1:0]     wait_cnt_r, wait_cnt_nxt;
  logic [NO_MASTERS-1:0] grant_r, grant_nxt;
  logic [BUS_W-1:0]      bus_nxt;
  logic                  timeout_nxt;
  logic [M_ID_WIDTH-1:0] win_s;
  logic                  win_valid_s;

  // Per-master frame receivers.
  for (genvar i = 0; i < NO_MASTERS; i++) begin : g_rx
    rx_state_e             rx_state_r, rx_state_nxt;
    logic [RX_CNT_W-1:0]   rx_cnt_r, rx_cnt_nxt;
    logic [S_ID_WIDTH-1:0] rx_shift_r, rx_shift_nxt;
    logic [S_ID_WIDTH-1:0] id_r, id_nxt;
    logic                  pending_r, pending_nxt;
    logic [S_ID_WIDTH-1:0] full_id_s;

    // Shift register contents including the bit on the line this cycle.
    assign full_id_s    = S_ID_WIDTH'({rx_shift_r, cmd_M[i]});
    assign pending_s[i] = pending_r;
    assign id_s[i]      = id_r;
    assign grant_M[i]   = grant_r[i];

    // Receiver next-state: decode start bit, collect ID, track hold/release.
    always_comb begin
      rx_state_nxt = rx_state_r;
      rx_cnt_nxt   = rx_cnt_r;
      rx_shift_nxt = rx_shift_r;
      id_nxt       = id_r;
      pending_nxt  = pending_r;
      if (drop_s[i]) begin
        // Abandoned by the arbiter: the master must send a fresh frame.
        rx_state_nxt = RX_IDLE;
        pending_nxt  = 1'b0;
      end else begin
        case (rx_state_r)
          RX_IDLE: begin
            if (cmd_M[i]) begin
              rx_state_nxt = RX_SHIFT;
              rx_cnt_nxt   = RX_CNT_ZERO;
              rx_shift_nxt = ID_ZERO;
            end else begin
              rx_state_nxt = RX_IDLE;
            end
          end
          RX_SHIFT: begin
            rx_shift_nxt = full_id_s;
            if (rx_cnt_r == RX_LAST) begin
              if (id_valid(full_id_s)) begin
                rx_state_nxt = RX_HOLD;
                pending_nxt  = 1'b1;
                id_nxt       = full_id_s;
              end else begin
                rx_state_nxt = RX_IDLE;
                pending_nxt  = 1'b0;
              end
            end else begin
              rx_cnt_nxt = rx_cnt_r + RX_CNT_ONE;
            end
          end
          RX_HOLD: begin
            if (!cmd_M[i]) begin
              rx_state_nxt = RX_IDLE;
              pending_nxt  = 1'b0;
            end else begin
              pending_nxt = 1'b1;
            end
          end
          default: begin
            rx_state_nxt = RX_IDLE;
            pending_nxt  = 1'b0;
          end
        endcase
      end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        rx_state_r <= RX_IDLE;
        rx_cnt_r   <= RX_CNT_ZERO;
        rx_shift_r <= ID_ZERO;
        id_r       <= ID_ZERO;
        pending_r  <= 1'b0;
      end else begin
        rx_state_r <= rx_state_nxt;
        rx_cnt_r   <= rx_cnt_nxt;
        rx_shift_r <= rx_shift_nxt;
        id_r       <= id_nxt;
        pending_r  <= pending_nxt;
      end
    end
  end

  // Round-robin pick starting at last_owner+1; descending scan lets the
  // nearest pending master overwrite farther ones.
  always_comb begin
    int cand;
    cand        = 0;
    win_s       = {M_ID_WIDTH{1'b0}};
    win_valid_s = 1'b0;
    for (int k = NO_MASTERS; k >= 1; k--) begin
      cand        = (int'(last_owner_r) + k) % NO_MASTERS;
      win_s       = pending_s[cand] ? M_ID_WIDTH'(cand) : win_s;
      win_valid_s = win_valid_s | pending_s[cand];
    end
  end

  // Arbiter next-state and next values of the registered outputs.
  always_comb begin
    state_nxt      = state_r;
    owner_nxt      = owner_r;
    last_owner_nxt = last_owner_r;
    wait_cnt_nxt   = wait_cnt_r;
    bus_nxt        = bus_state;
    grant_nxt      = {NO_MASTERS{1'b0}};
    timeout_nxt    = 1'b0;
    drop_s         = {NO_MASTERS{1'b0}};
    case (state_r)
      IDLE: begin
        wait_cnt_nxt = WAIT_ZERO;
        if (win_valid_s) begin
          owner_nxt = win_s;
          bus_nxt   = {win_s, id_s[win_s]};
          state_nxt = CONNECT;
        end else begin
          bus_nxt = BUS_NONE;
        end
      end
      CONNECT: begin
        // Cancel is checked before ready so it wins when both occur.
        if (!pending_s[owner_r]) begin
          state_nxt      = RELEASE;
          last_owner_nxt = owner_r;
          bus_nxt        = BUS_NONE;
        end else if (ready) begin
          state_nxt          = GRANT;
          grant_nxt[owner_r] = 1'b1;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt       = RELEASE;
          last_owner_nxt  = owner_r;
          bus_nxt         = BUS_NONE;
          timeout_nxt     = 1'b1;
          drop_s[owner_r] = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt_r + WAIT_ONE;
        end
      end
      GRANT: begin
        if (!cmd_M[owner_r]) begin
          state_nxt      = RELEASE;
          last_owner_nxt = owner_r;
          bus_nxt        = BUS_NONE;
        end else begin
          grant_nxt[owner_r] = 1'b1;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        bus_nxt   = BUS_NONE;
      end
      default: begin
        state_nxt = IDLE;
        bus_nxt   = BUS_NONE;
      end
    endcase
  end

  // Arbiter state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= {M_ID_WIDTH{1'b0}};
      last_owner_r <= OWNER_RST;
      wait_cnt_r   <= WAIT_ZERO;
      grant_r      <= {NO_MASTERS{1'b0}};
      bus_state    <= BUS_NONE;
      timeout      <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      owner_r      <= owner_nxt;
      last_owner_r <= last_owner_nxt;
      wait_cnt_r   <= wait_cnt_nxt;
      grant_r      <= grant_nxt;
      bus_state    <= bus_nxt;
      timeout      <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: single request, contention with
// round-robin, invalid ID, timeout, cancel in CONNECT and mid-grant reset.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       cmd_M [0:1];
  logic       grant_M [0:1];
  logic       ready;
  logic [2:0] bus_state;
  logic       timeout;

  int total_cnt;
  int bad_cnt;

  bus_arbiter #(
    .NO_MASTERS(2),
    .NO_SLAVES (3),
    .TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_M    (cmd_M),
    .grant_M  (grant_M),
    .ready    (ready),
    .bus_state(bus_state),
    .timeout  (timeout)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    cmd_M[0] = 1'b0;
    cmd_M[1] = 1'b0;
    ready    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Start bit plus 2 ID bits (3 edges); enabled masters then hold the line.
  task automatic send_frames(input logic en0, input logic [1:0] id0,
                             input logic en1, input logic [1:0] id1);
    cmd_M[0] = en0;
    cmd_M[1] = en1;
    step();
    cmd_M[0] = en0 & id0[1];
    cmd_M[1] = en1 & id1[1];
    step();
    cmd_M[0] = en0 & id0[0];
    cmd_M[1] = en1 & id1[0];
    step();
    cmd_M[0] = en0;
    cmd_M[1] = en1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    cmd_M[0]  = 1'b0;
    cmd_M[1]  = 1'b0;
    ready     = 1'b0;
    repeat (3) step();

    // Reset state.
    check_val("rst_bus",     32'(bus_state),  32'h0);
    check_val("rst_grant0",  32'(grant_M[0]), 32'h0);
    check_val("rst_grant1",  32'(grant_M[1]), 32'h0);
    check_val("rst_timeout", 32'(timeout),    32'h0);
    rst = 1'b0;
    step();

    // Single request: master 0 -> slave 2, ready high.
    ready = 1'b1;
    send_frames(1'b1, 2'd2, 1'b0, 2'd0);
    check_val("single_pre_bus", 32'(bus_state), 32'h0);
    step();
    check_val("single_bus",     32'(bus_state),  32'b0_10);
    check_val("single_nogrant", 32'(grant_M[0]), 32'h0);
    step();
    check_val("single_grant0", 32'(grant_M[0]), 32'h1);
    check_val("single_grant1", 32'(grant_M[1]), 32'h0);
    step();
    step();
    check_val("single_hold", 32'(grant_M[0]), 32'h1);
    cmd_M[0] = 1'b0;
    step();
    check_val("single_rel_grant", 32'(grant_M[0]), 32'h0);
    check_val("single_rel_bus",   32'(bus_state),  32'h0);

    // Contention: both request slave 1 together.
    do_reset();
    ready = 1'b1;
    send_frames(1'b1, 2'd1, 1'b1, 2'd1);
    step();
    check_val("cont_bus0", 32'(bus_state), 32'b0_01);
    step();
    check_val("cont_grant0", 32'(grant_M[0]), 32'h1);
    check_val("cont_grant1", 32'(grant_M[1]), 32'h0);
    cmd_M[0] = 1'b0;
    step();
    check_val("cont_rel_grant0", 32'(grant_M[0]), 32'h0);
    check_val("cont_rel_bus",    32'(bus_state),  32'h0);
    step();
    check_val("cont_idle_bus", 32'(bus_state), 32'h0);
    step();
    check_val("cont_bus1", 32'(bus_state), 32'b1_01);
    step();
    check_val("cont_m1_grant1", 32'(grant_M[1]), 32'h1);
    check_val("cont_m1_grant0", 32'(grant_M[0]), 32'h0);
    cmd_M[1] = 1'b0;
    step();
    step();
    send_frames(1'b1, 2'd1, 1'b1, 2'd1);
    step();
    check_val("rr_bus", 32'(bus_state), 32'b0_01);
    step();
    check_val("rr_grant0", 32'(grant_M[0]), 32'h1);

    // Invalid ID: master 1 sends ID 0 then drops its line.
    do_reset();
    ready = 1'b1;
    send_frames(1'b0, 2'd0, 1'b1, 2'd0);
    cmd_M[1] = 1'b0;
    step();
    check_val("inv_bus_a", 32'(bus_state), 32'h0);
    repeat (4) step();
    check_val("inv_bus_b",  32'(bus_state),  32'h0);
    check_val("inv_grant1", 32'(grant_M[1]), 32'h0);

    // Timeout: master 0 -> slave 3 with ready low; master 1 queues slave 2.
    do_reset();
    send_frames(1'b1, 2'd3, 1'b0, 2'd0);
    step();
    check_val("to_bus", 32'(bus_state), 32'b0_11);
    cmd_M[1] = 1'b1;
    step();
    cmd_M[1] = 1'b1;
    step();
    cmd_M[1] = 1'b0;
    step();
    cmd_M[1] = 1'b1;
    repeat (12) step();
    check_val("to_early",     32'(timeout),   32'h0);
    check_val("to_early_bus", 32'(bus_state), 32'b0_11);
    step();
    check_val("to_pulse",  32'(timeout),    32'h1);
    check_val("to_bus0",   32'(bus_state),  32'h0);
    check_val("to_grant0", 32'(grant_M[0]), 32'h0);
    cmd_M[0] = 1'b0;
    step();
    check_val("to_pulse_end", 32'(timeout), 32'h0);
    step();
    check_val("to_next_bus", 32'(bus_state), 32'b1_10);
    ready = 1'b1;
    step();
    check_val("to_next_grant1", 32'(grant_M[1]), 32'h1);
    check_val("to_next_grant0", 32'(grant_M[0]), 32'h0);

    // Cancel in CONNECT: master 1 drops; ready rises in the cancel cycle.
    do_reset();
    send_frames(1'b0, 2'd0, 1'b1, 2'd1);
    step();
    check_val("can_bus", 32'(bus_state), 32'b1_01);
    cmd_M[1] = 1'b0;
    step();
    check_val("can_bus_hold", 32'(bus_state),  32'b1_01);
    check_val("can_nogrant_a", 32'(grant_M[1]), 32'h0);
    ready = 1'b1;
    step();
    check_val("can_nogrant_b", 32'(grant_M[1]), 32'h0);
    check_val("can_rel_bus",   32'(bus_state),  32'h0);
    check_val("can_no_to_a",   32'(timeout),    32'h0);
    step();
    check_val("can_nogrant_c", 32'(grant_M[1]), 32'h0);
    check_val("can_no_to_b",   32'(timeout),    32'h0);

    // Reset during GRANT.
    do_reset();
    ready = 1'b1;
    send_frames(1'b1, 2'd2, 1'b0, 2'd0);
    step();
    step();
    check_val("mrst_grant_before", 32'(grant_M[0]), 32'h1);
    rst = 1'b1;
    step();
    check_val("mrst_grant", 32'(grant_M[0]), 32'h0);
    check_val("mrst_bus",   32'(bus_state),  32'h0);
    rst      = 1'b0;
    cmd_M[0] = 1'b0;
    repeat (3) step();
    check_val("mrst_idle_bus",   32'(bus_state),  32'h0);
    check_val("mrst_idle_grant", 32'(grant_M[0]), 32'h0);
    send_frames(1'b1, 2'd2, 1'b0, 2'd0);
    step();
    check_val("mrst_resend_bus", 32'(bus_state), 32'b0_10);
    step();
    check_val("mrst_resend_grant", 32'(grant_M[0]), 32'h1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
